// File: rtl/debug_pkg.sv
// Shared types and constants for the debug register dump path.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LATCH,
    SEND,
    WAIT_DONE,
    NEXT,
    CHKSUM,
    DONE
  } dump_state_t;

  localparam int BYTE_NB        = 8;
  localparam int BYTES_PER_WORD = 32 / BYTE_NB;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one captured register word and presents it MSB byte first;
// the FSM strobes load to capture and shift to advance one byte.
module word_byte_serializer
  import debug_pkg::*;
#(
  parameter int NB      = 32,
  parameter int BYTE_NB = debug_pkg::BYTE_NB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [NB-1:0]      data_in,
  output logic [BYTE_NB-1:0] top_byte,
  output logic               last_byte
);

  localparam int WORD_BYTES = NB / BYTE_NB;
  localparam int CW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_BYTES - 1);

  logic [NB-1:0] shift_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= data_in;
      cnt_q   <= '0;
    end else if (shift) begin
      shift_q <= shift_q << BYTE_NB;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  assign top_byte  = shift_q[NB-1 -: BYTE_NB];
  assign last_byte = (cnt_q == LAST_CNT);

endmodule

// File: rtl/debug_reg_dump.sv
// Sweeps the register-file debug port and streams every word, MSB byte
// first, to the UART TX. DEBUG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
//
// state     | meaning
// IDLE      | waiting for i_start
// SELECT    | index on the debug port, read data settling
// LATCH     | capture word into the serializer
// SEND      | register top byte, raise tx start
// WAIT_DONE | hold byte until i_tx_done
// NEXT      | advance index or finish
// CHKSUM    | send checksum byte (checksum build only)
// DONE      | one-cycle completion pulse
module debug_reg_dump
  import debug_pkg::*;
#(
  parameter int NB       = 32,
  parameter int REGS     = 5,
  parameter int NUM_REGS = 32,
  parameter int BYTE_NB  = debug_pkg::BYTE_NB
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB-1:0]      i_data_tx_debug,
  input  logic               i_tx_done,
  output logic [REGS-1:0]    o_select_reg_dir,
  output logic [BYTE_NB-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [REGS-1:0] LAST_IDX = REGS'(NUM_REGS - 1);

  dump_state_t        state_q, state_d;
  logic [REGS-1:0]    idx_q;
  logic [BYTE_NB-1:0] tx_data_q;
  logic               tx_start_q;
  logic               idx_clr, idx_inc;
  logic               ser_load, ser_shift, ser_last;
  logic [BYTE_NB-1:0] ser_byte;
  logic [BYTE_NB-1:0] chk_byte;
  logic               chk_phase;

  word_byte_serializer #(.NB(NB), .BYTE_NB(BYTE_NB)) u_ser (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .load     (ser_load),
    .shift    (ser_shift),
    .data_in  (i_data_tx_debug),
    .top_byte (ser_byte),
    .last_byte(ser_last)
  );

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
  logic [BYTE_NB-1:0] chk_q;
  logic               chk_phase_q;

  // chk_phase_q marks that the byte in flight is the checksum itself
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      chk_q       <= '0;
      chk_phase_q <= 1'b0;
    end else begin
      if (idx_clr)              chk_q <= '0;
      else if (state_q == SEND) chk_q <= chk_q ^ ser_byte;
      if (idx_clr)                chk_phase_q <= 1'b0;
      else if (state_q == CHKSUM) chk_phase_q <= 1'b1;
    end
  end

  assign chk_byte  = chk_q;
  assign chk_phase = chk_phase_q;
`else
  localparam bit CHK_EN = 1'b0;
  assign chk_byte  = '0;
  assign chk_phase = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          idx_clr = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: state_d = LATCH;
      LATCH: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done) begin
          if (chk_phase) begin
            state_d = DONE;
          end else begin
            ser_shift = 1'b1;
            if (ser_last) state_d = NEXT;
            else          state_d = SEND;
          end
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          if (CHK_EN) state_d = CHKSUM;
          else        state_d = DONE;
        end else begin
          idx_inc = 1'b1;
          state_d = SELECT;
        end
      end
      CHKSUM: state_d = WAIT_DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= (state_q == SEND) || (state_q == CHKSUM);
      if (state_q == SEND)        tx_data_q <= ser_byte;
      else if (state_q == CHKSUM) tx_data_q <= chk_byte;
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + REGS'(1);
    end
  end

  assign o_select_reg_dir = idx_q;
  assign o_tx_data        = tx_data_q;
  assign o_tx_start       = tx_start_q;
  assign o_busy           = (state_q != IDLE);
  assign o_done           = (state_q == DONE);

endmodule

// File: tb/tb_debug_reg_dump.sv
// Bench for debug_reg_dump: register-file and UART models, expected byte
// stream built from the register contents, per-cycle compare process.
module tb_debug_reg_dump;

  localparam int NB       = 32;
  localparam int REGS     = 5;
  localparam int NUM_REGS = 32;
  localparam int BYTE_NB  = 8;
  localparam int WB       = NB / BYTE_NB;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int TOTAL    = NUM_REGS * WB + CHK;
  localparam int DONE_GAP = (CHK != 0) ? 1 : 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               done_m = 1'b0;
  logic               done_inj = 1'b0;
  logic               tx_done;
  logic [NB-1:0]      regs [NUM_REGS];
  logic [NB-1:0]      rd_data;
  logic [REGS-1:0]    sel;
  logic [BYTE_NB-1:0] tx_data;
  logic               tx_start, busy, done;

  assign rd_data = regs[sel];
  assign tx_done = done_m | done_inj;

  always #5 clk = ~clk;

  debug_reg_dump #(.NB(NB), .REGS(REGS), .NUM_REGS(NUM_REGS), .BYTE_NB(BYTE_NB)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_start         (start),
    .i_data_tx_debug (rd_data),
    .i_tx_done       (tx_done),
    .o_select_reg_dir(sel),
    .o_tx_data       (tx_data),
    .o_tx_start      (tx_start),
    .o_busy          (busy),
    .o_done          (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART model: done pulse tx_delay cycles after a start; optional echo
  // of each done one cycle later, which lands in the following SEND cycle.
  int tx_delay = 3;
  bit rand_delay = 0;
  bit inject = 0;
  int pend = 0;

  always @(posedge clk) begin
    #1;
    done_inj = (inject && done_m) ? 1'b1 : 1'b0;
    done_m = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) done_m = 1'b1;
      end
      if (tx_start) pend = rand_delay ? int'($urandom_range(1, 6)) : tx_delay;
    end
  end

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         n_sent = 0;
  int         dones = 0;
  logic [7:0] last_tx = 8'h00;
  longint     cyc = 0;
  longint     last_done_cyc = 0;
  bit         prev_start = 0;

  always @(negedge clk) begin
    logic [7:0] eb;
    cyc++;
    if (rst_n) begin
      if (tx_start) begin
        check("start_pulse_width", 64'(prev_start), 64'd0);
        if (exp_q.size() == 0) begin
          check("byte_overflow", 64'(n_sent + 1), 64'(TOTAL));
        end else begin
          eb = exp_q.pop_front();
          check("tx_byte", 64'(tx_data), 64'(eb));
          check("select_idx", 64'(sel),
                64'((n_sent < NUM_REGS * WB) ? n_sent / WB : NUM_REGS - 1));
        end
        got_q.push_back(tx_data);
        last_tx = tx_data;
        n_sent++;
      end else if (busy && n_sent > 0) begin
        check("tx_hold", 64'(tx_data), 64'(last_tx));
      end
      if (done_m && busy) last_done_cyc = cyc;
      if (done) begin
        dones++;
        check("done_byte_count", 64'(n_sent), 64'(TOTAL));
        check("done_busy", 64'(busy), 64'd1);
        check("done_gap", 64'(cyc - last_done_cyc), 64'(DONE_GAP));
      end
      if (!busy) check("idle_no_start", 64'(tx_start), 64'd0);
    end
    prev_start = tx_start;
  end

  task automatic start_dump();
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    exp_q.delete();
    got_q.delete();
    n_sent = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < WB; k++) begin
        b = regs[r][8 * (WB - 1 - k) +: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
    if (CHK != 0) exp_q.push_back(c);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_dump(input string name, input int budget);
    int d0;
    int n;
    d0 = dones;
    n = 0;
    while (dones == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed"}, 64'(n < budget), 64'd1);
    @(negedge clk); #1;
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_done_once"}, 64'(dones - d0), 64'd1);
    check({name, "_bytes"}, 64'(got_q.size()), 64'(TOTAL));
  endtask

  task automatic wait_sent(input int target, input int budget);
    int n;
    n = 0;
    while (n_sent < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_sent_reached", 64'(n < budget), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA000_0000 + 32'(i);
    #1 rst_n = 1'b0;
    #2;
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Incrementing pattern
    start_dump();
    wait_dump("incr", 3000);
    check("incr_b0", 64'(got_q[0]), 64'hA0);
    check("incr_b3", 64'(got_q[3]), 64'h00);
    check("incr_b7", 64'(got_q[7]), 64'h01);
    check("incr_b127", 64'(got_q[127]), 64'h1F);
    if (CHK != 0) check("incr_chk", 64'(got_q[128]), 64'h00);

    // Single non-zero register
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    regs[5] = 32'h1234_5678;
    start_dump();
    wait_dump("reg5", 3000);
    check("reg5_b20", 64'(got_q[20]), 64'h12);
    check("reg5_b21", 64'(got_q[21]), 64'h34);
    check("reg5_b22", 64'(got_q[22]), 64'h56);
    check("reg5_b23", 64'(got_q[23]), 64'h78);
    check("reg5_b24", 64'(got_q[24]), 64'h00);
    if (CHK != 0) check("reg5_chk", 64'(got_q[128]), 64'h08);

    // Re-start while busy and done pulses echoed into SEND cycles
    inject = 1;
    start_dump();
    repeat (40) @(posedge clk);
    #1 check("restart_busy_a", 64'(busy), 64'd1);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    repeat (250) @(posedge clk);
    #1 check("restart_busy_b", 64'(busy), 64'd1);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    wait_dump("restart", 3000);
    check("restart_b23", 64'(got_q[23]), 64'h78);
    inject = 0;

    // Random contents and random UART latency
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    rand_delay = 1;
    start_dump();
    wait_dump("random", 4000);
    rand_delay = 0;

    // Reset while waiting on the first byte of register 10
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA000_0000 + 32'(i);
    start_dump();
    wait_sent(41, 3000);
    @(posedge clk); #2;
    check("abort_sel_before", 64'(sel), 64'd10);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_sel", 64'(sel), 64'd0);
    check("abort_tx_data", 64'(tx_data), 64'd0);
    check("abort_tx_start", 64'(tx_start), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);
    end
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle_after", 64'(busy), 64'd0);
    start_dump();
    wait_dump("post_reset", 3000);
    check("post_reset_b0", 64'(got_q[0]), 64'hA0);
    check("post_reset_b3", 64'(got_q[3]), 64'h00);

    // UART stalls for 1000 cycles on the first byte
    tx_delay = 1000;
    start_dump();
    wait_sent(1, 100);
    tx_delay = 3;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 990; i++) begin
        @(negedge clk);
        if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA0 || sel !== 5'd0) bad++;
      end
      check("stall_hold_cycles_bad", 64'(bad), 64'd0);
      check("stall_sent", 64'(n_sent), 64'd1);
    end
    wait_dump("stall", 3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
